// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Purpose: bundles the requester handshake and the uart_tx handshake that
//          connect the byte producers, the arbiter and the shared transmitter.
// Signals:
//   req_valid  NUM_REQ            per-requester byte available
//   req_data   NUM_REQ*DATA_BITS  requester i byte at [i*DATA_BITS +: DATA_BITS]
//   req_ready  NUM_REQ            one-hot pulse, byte of requester i captured
//   tx_valid   1                  valid towards uart_tx
//   tx_data    DATA_BITS          byte towards uart_tx, stable while tx_valid
//   tx_ready   1                  ready from uart_tx
//   grant_id   ID_W               current/last granted requester
//   busy       1                  arbiter not idle
// Modports:
//   slave  - the arbiter itself
//   master - the surroundings (producers + uart_tx)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tx_valid;
  logic [DATA_BITS-1:0]         tx_data;
  logic                         tx_ready;
  logic [ID_W-1:0]              grant_id;
  logic                         busy;

  modport slave (
    input  req_valid, req_data, tx_ready,
    output req_ready, tx_valid, tx_data, grant_id, busy
  );

  modport master (
    output req_valid, req_data, tx_ready,
    input  req_ready, tx_valid, tx_data, grant_id, busy
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Purpose: shares one uart_tx transmitter between NUM_REQ byte producers.
//          Round-robin grant with bounded bursts (MAX_BURST bytes per grant),
//          one byte captured per grant into a holding register, and the next
//          byte released only after uart_tx reports the frame finished.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    uart_tx_arbiter_if.slave (requester and uart_tx handshakes,
//          grant_id, busy)
// Optional feature:
//   UART_ARB_ID_PREFIX_EN - when defined, every new grant out of IDLE first
//   sends a header byte {1'b1, zero-pad, grant_id}; burst continuations send
//   no header and the header does not count against MAX_BURST.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_arbiter_if.slave    bus
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int SUM_W = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;

  logic                 pickFound;
  logic [ID_W-1:0]      pickIdx;
  logic [DATA_BITS-1:0] pickData;
  logic [DATA_BITS-1:0] grantData;
  logic [SUM_W-1:0]     sum;

`ifdef UART_ARB_ID_PREFIX_EN
  logic                 hdr_q, hdr_d;
  logic [DATA_BITS-1:0] hdrByte;
`endif

  // Round-robin search: first valid requester at or after the pointer,
  // wrapping from NUM_REQ-1 back to 0. The extra sum bit keeps ptr+k from
  // overflowing before the wrap subtraction.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    pickData  = '0;
    sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      if (!pickFound && bus.req_valid[sum[ID_W-1:0]]) begin
        pickFound = 1'b1;
        pickIdx   = sum[ID_W-1:0];
        pickData  = bus.req_data[int'(sum[ID_W-1:0])*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Byte offered by the requester currently holding the grant, used when a
  // burst continues straight out of DRAIN.
  always_comb begin
    grantData = bus.req_data[int'(grant_q)*DATA_BITS +: DATA_BITS];
  end

  // Next-state logic. IDLE grants only when uart_tx is ready; LAUNCH holds
  // tx_valid until uart_tx drops ready (frame started); DRAIN waits for the
  // frame to end, then either continues the burst or rotates the pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    ready_d = '0;
`ifdef UART_ARB_ID_PREFIX_EN
    hdr_d   = hdr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pickFound && bus.tx_ready) begin
          ready_d[pickIdx] = 1'b1;
          hold_d           = pickData;
          grant_d          = pickIdx;
          cnt_d            = CNT_W'(1);
          state_d          = LAUNCH;
`ifdef UART_ARB_ID_PREFIX_EN
          hdr_d            = 1'b1;
`endif
        end
      end
      LAUNCH: begin
        if (!bus.tx_ready) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.tx_ready) begin
`ifdef UART_ARB_ID_PREFIX_EN
          // Header just went out: send the byte already held, no new capture.
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = LAUNCH;
          end else
`endif
          if (bus.req_valid[grant_q] && (cnt_q < CNT_W'(MAX_BURST))) begin
            ready_d[grant_q] = 1'b1;
            hold_d           = grantData;
            cnt_d            = cnt_q + CNT_W'(1);
            state_d          = LAUNCH;
          end else begin
            ptr_d   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset drops any byte in flight; nothing is retried.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      ready_q <= '0;
`ifdef UART_ARB_ID_PREFIX_EN
      hdr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
`ifdef UART_ARB_ID_PREFIX_EN
      hdr_q   <= hdr_d;
`endif
    end
  end

`ifdef UART_ARB_ID_PREFIX_EN
  // Header byte: MSB set, requester id in the low bits, zeros between.
  always_comb begin
    hdrByte                = '0;
    hdrByte[DATA_BITS-1]   = 1'b1;
    hdrByte[ID_W-1:0]      = grant_q;
  end
  assign bus.tx_data = hdr_q ? hdrByte : hold_q;
`else
  assign bus.tx_data = hold_q;
`endif

  assign bus.tx_valid  = (state_q == LAUNCH);
  assign bus.req_ready = ready_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
